// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK flip-flop bank between two requesters.
// Each accepted command drives J/K for one cycle, then reports completion
// with the bank state captured after the update.
module jk_bank_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_sel,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_sel,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] Q,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] q_last
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CAPTURE
  } state_t;

  state_t           state, state_nxt;
  logic             ptr;        // requester favoured when both are valid
  logic             grant;
  logic             accept;
  logic             id_r;
  logic [WIDTH-1:0] sel_g;
  logic [1:0]       op_g;
  logic [WIDTH-1:0] j_r, k_r;
  logic [WIDTH-1:0] q_last_r;

  // Arbitration: a lone requester wins, a tie goes to the favoured one
  always_comb begin
    grant  = 1'b0;
    accept = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ptr;
    end else begin
      grant = req1_valid;
    end
    accept = (state == IDLE) && (req0_valid || req1_valid);
    sel_g  = grant ? req1_sel : req0_sel;
    op_g   = grant ? req1_op  : req0_op;
  end

  // Next-state: IDLE -> DRIVE -> CAPTURE -> IDLE, one cycle each when busy
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRIVE;
      DRIVE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command capture: the mapped J/K is loaded on acceptance and cleared on
  // the following edge, so it is non-zero only during DRIVE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr  <= 1'b0;
      id_r <= 1'b0;
      j_r  <= '0;
      k_r  <= '0;
    end else begin
      if (accept) begin
        ptr  <= ~grant;
        id_r <= grant;
        j_r  <= sel_g & {WIDTH{op_g[1]}};
        k_r  <= sel_g & {WIDTH{op_g[0]}};
      end else begin
        j_r <= '0;
        k_r <= '0;
      end
    end
  end

  // Bank snapshot taken at the edge that ends CAPTURE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q_last_r <= '0;
    end else if (state == CAPTURE) begin
      q_last_r <= Q;
    end
  end

  // Outputs; ready is gated by n_rst so both stay low while reset is held
  always_comb begin
    req0_ready = n_rst && accept && !grant;
    req1_ready = n_rst && accept && grant;
    J          = j_r;
    K          = k_r;
    done       = (state == CAPTURE);
    done_id    = id_r;
    q_last     = q_last_r;
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Testbench for jk_bank_arbiter: a behavioural JK bank, a transaction-level
// model checked every cycle, and directed sequences with literal expectations.
module tb_jk_bank_arbiter;

  logic       clk;
  logic       n_rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_sel, req1_sel;
  logic [1:0] req0_op, req1_op;
  logic [3:0] J, K, Q, q_last;
  logic       done, done_id;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  jk_bank_arbiter #(.WIDTH(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_sel   (req0_sel),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_sel   (req1_sel),
    .req1_op    (req1_op),
    .J          (J),
    .K          (K),
    .Q          (Q),
    .done       (done),
    .done_id    (done_id),
    .q_last     (q_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // The JK flip-flop bank shares clk/n_rst with the arbiter
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) Q <= '0;
    else        Q <= (J & ~Q) | (~K & Q);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction model: age 0 idle, 1 the cycle driving the bank, 2 completion
  int         m_age   = 0;
  logic       m_fav   = 1'b0;
  logic       m_id    = 1'b0;
  logic [3:0] m_sel   = '0;
  logic [1:0] m_op    = '0;
  logic [3:0] m_q     = '0;
  logic [3:0] m_qlast = '0;
  logic       m_any, m_g;
  logic [3:0] m_ej, m_ek;

  always @(negedge clk) begin
    if (!n_rst) begin
      m_age = 0; m_fav = 1'b0; m_id = 1'b0; m_q = '0; m_qlast = '0;
    end
    m_any = n_rst && (m_age == 0) && (req0_valid || req1_valid);
    m_g   = (req0_valid && req1_valid) ? m_fav : req1_valid;
    m_ej  = (m_age == 1 && m_op[1]) ? m_sel : 4'b0000;
    m_ek  = (m_age == 1 && m_op[0]) ? m_sel : 4'b0000;
    chk("m_ready0", req0_ready, m_any && !m_g);
    chk("m_ready1", req1_ready, m_any && m_g);
    chk("m_J", J, m_ej);
    chk("m_K", K, m_ek);
    chk("m_done", done, m_age == 2);
    chk("m_done_id", done_id, m_id);
    chk("m_q_last", q_last, m_qlast);
    chk("m_Q", Q, m_q);
    if (n_rst) begin
      case (m_age)
        0: if (m_any) begin
             m_age = 1; m_id = m_g; m_fav = !m_g;
             m_sel = m_g ? req1_sel : req0_sel;
             m_op  = m_g ? req1_op  : req0_op;
           end
        1: begin
             case (m_op)
               2'b01:   m_q = m_q & ~m_sel;
               2'b10:   m_q = m_q | m_sel;
               2'b11:   m_q = m_q ^ m_sel;
               default: m_q = m_q;
             endcase
             m_age = 2;
           end
        default: begin m_qlast = m_q; m_age = 0; end
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for ready on requester id; returns at negedge+1 of handshake
  task automatic wait_ready(input int id);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk); #1;
      got = (id == 0) ? req0_ready : req1_ready;
      if (!got) begin @(posedge clk); #1; end
    end
    if (!got) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input int id, input logic [3:0] sel, input logic [1:0] op);
    if (id == 0) begin req0_valid = 1'b1; req0_sel = sel; req0_op = op; end
    else         begin req1_valid = 1'b1; req1_sel = sel; req1_op = op; end
    wait_ready(id);
    step();
    if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Called at the start of DRIVE; leaves at the start of the next IDLE cycle
  task automatic expect_seq(input string tag, input logic [3:0] ej, input logic [3:0] ek,
                            input logic id, input logic [3:0] ql);
    chk({tag, "_J"}, J, ej);
    chk({tag, "_K"}, K, ek);
    step();
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_done_id"}, done_id, id);
    step();
    chk({tag, "_q_last"}, q_last, ql);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int   ng;
  int   gcyc [4];
  logic gids [4];

  initial begin
    n_rst = 1'b0;
    req0_valid = 1'b0; req0_sel = '0; req0_op = '0;
    req1_valid = 1'b0; req1_sel = '0; req1_op = '0;
    step(); step();
    chk("rst_J", J, 4'b0000);
    chk("rst_done", done, 1'b0);
    chk("rst_q_last", q_last, 4'b0000);
    n_rst = 1'b1;
    step();

    // req0 set on bits 1:0
    send(0, 4'b0011, 2'b10);
    expect_seq("set0", 4'b0011, 4'b0000, 1'b0, 4'b0011);

    // req1 toggle all bits
    send(1, 4'b1111, 2'b11);
    expect_seq("tog1", 4'b1111, 4'b1111, 1'b1, 4'b1100);

    // Both valid continuously, toggling bit 0: grants must alternate from req0
    req0_valid = 1'b1; req0_sel = 4'b0001; req0_op = 2'b11;
    req1_valid = 1'b1; req1_sel = 4'b0001; req1_op = 2'b11;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk); #1;
      if (req0_ready || req1_ready) begin
        gids[ng] = req1_ready; gcyc[ng] = cyc; ng++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", ng, 4);
    chk("rr_g0", gids[0], 1'b0);
    chk("rr_g1", gids[1], 1'b1);
    chk("rr_g2", gids[2], 1'b0);
    chk("rr_g3", gids[3], 1'b1);
    chk("rr_gap01", gcyc[1] - gcyc[0], 3);
    chk("rr_gap23", gcyc[3] - gcyc[2], 3);
    step(); step();
    chk("rr_Q", Q, 4'b1100);

    // Reset bit 2, then a hold on everything
    send(0, 4'b0100, 2'b01);
    expect_seq("rst0", 4'b0000, 4'b0100, 1'b0, 4'b1000);
    send(1, 4'b1111, 2'b00);
    expect_seq("hold1", 4'b0000, 4'b0000, 1'b1, 4'b1000);

    // Reset pulled low during DRIVE of a set command; req0 stays pending
    req0_valid = 1'b1; req0_sel = 4'b0011; req0_op = 2'b10;
    wait_ready(0);
    step();
    chk("mid_J_before", J, 4'b0011);
    n_rst = 1'b0;
    #2;
    chk("mid_J", J, 4'b0000);
    chk("mid_K", K, 4'b0000);
    chk("mid_done", done, 1'b0);
    chk("mid_q_last", q_last, 4'b0000);
    chk("mid_Q", Q, 4'b0000);
    chk("mid_ready0", req0_ready, 1'b0);
    step(); step();
    chk("mid_done_held", done, 1'b0);
    n_rst = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_ready0", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    expect_seq("post_rst", 4'b0011, 4'b0000, 1'b0, 4'b0011);

    // req0 arrives during DRIVE, req1 re-arrives during CAPTURE
    req1_valid = 1'b1; req1_sel = 4'b0001; req1_op = 2'b11;
    wait_ready(1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_sel = 4'b1000; req0_op = 2'b10;
    @(negedge clk); #1;
    chk("busy_drive_ready0", req0_ready, 1'b0);
    step();
    req1_valid = 1'b1; req1_sel = 4'b0100; req1_op = 2'b10;
    @(negedge clk); #1;
    chk("busy_cap_ready0", req0_ready, 1'b0);
    chk("busy_cap_ready1", req1_ready, 1'b0);
    step();
    @(negedge clk); #1;
    chk("idle_ready0", req0_ready, 1'b1);
    chk("idle_ready1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    wait_ready(1);
    step();
    req1_valid = 1'b0;
    step(); step();
    chk("final_q_last", q_last, 4'b1110);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
